tx_burst_scheduler: RTL and testbench
=====================================

Name: tx_burst_scheduler

Overview:
- Multiplexes NUM_CH frame-source channels onto the single 64-bit TX data path that feeds the Interlaken transmit lane logic. Sources are frame_gen-style producers.
- Grants channels round-robin, cuts packets into bursts of at most BURST_MAX words, and inserts a burst/idle control word before each burst and after the last one.
- Uses a one-stage registered output with a valid/ready handshake toward the transmitter.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- BURST_MAX, 8, maximum data words per burst (2..255).

Ports:
- USER_CLK  in  1  system clock; all logic on rising edge.
- SYSTEM_RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  scheduler enable; sampled only at burst boundaries.
- CH_DATA_IN  in  NUM_CH*64  per-channel data; channel c occupies [64c+63:64c].
- CH_VALID_IN  in  NUM_CH  per-channel word valid.
- CH_LAST_IN  in  NUM_CH  per-channel end-of-packet, qualified by valid.
- CH_READY_OUT  out  NUM_CH  per-channel accept; one-hot or zero.
- TX_DATA_OUT  out  64  output word (data or control).
- TX_CTRL_OUT  out  1  1 = TX_DATA_OUT is a control word.
- TX_DATA_TO_SEND  out  1  output word valid.
- DATA_IN_READY  in  1  downstream accepts the current word.
- CUR_CH_OUT  out  4  currently granted channel (status only).

Behaviour:
- Reset (async assert, sync release): TX_DATA_OUT=0, TX_CTRL_OUT=0, TX_DATA_TO_SEND=0, CUR_CH_OUT=0, state=IDLE, burst_cnt=0, rr pointer=NUM_CH-1 (so ch0 wins first), sop_pending[all]=1.
- load_en = !TX_DATA_TO_SEND || DATA_IN_READY. The output register changes only when load_en=1. With load_en=0, TX_DATA_OUT, TX_CTRL_OUT and TX_DATA_TO_SEND hold.
- Control word layout:
  - [63]=1
  - [62] type: 1=burst, 0=idle
  - [61] SOP of next burst
  - [60] EOP of previous burst
  - [47:40] channel of next burst (0 for idle)
  - all other bits 0
- Arbitration: round-robin starting at rr pointer+1 over CH_VALID_IN. The pointer updates to the winner when a burst control word loads.
- IDLE state:
  - Output valid drops when the held word is accepted.
  - If load_en & ENABLE & |CH_VALID_IN: load burst ctrl word (SOP=sop_pending[win], EOP=0, ch=win), latch grant, clear burst_cnt, go to DATA. The ctrl word is valid one cycle after the request is seen.
- DATA state:
  - CH_READY_OUT[grant]=load_en. The other CH_READY_OUT bits are 0.
  - Transfer when CH_VALID_IN[grant]&CH_READY_OUT[grant]: load the data word, TX_CTRL_OUT=0, valid=1, burst_cnt+1, sop_pending[grant]=0.
  - If the granted channel is not valid with load_en=1, TX_DATA_TO_SEND=0 (bubble). The grant is never switched mid-burst.
  - The burst ends on a transfer with CH_LAST_IN (eop_flag=1, sop_pending[grant]=1) or with burst_cnt reaching BURST_MAX (eop_flag=0). Then go to ARB.
- ARB state, on load_en:
  - If ENABLE & |CH_VALID_IN: load burst ctrl word (EOP=eop_flag, SOP, ch=win) and go to DATA. The next burst may be the same channel if it is the only one valid, or the packet continues.
  - Otherwise load idle ctrl word (EOP=eop_flag) and go to IDLE.
- ENABLE deassert mid-burst: the burst completes, then the idle control word is sent. The remainder of a split packet waits with sop_pending=0.
- Reset mid-burst: everything clears immediately. No trailing control word is sent.
- CUR_CH_OUT = latched grant, zero-extended.

Decomposition:
- Package interlaken_tx_pkg holds:
  - control-word bit positions and field constants (CW_CTRL, CW_BURST, CW_SOP, CW_EOP, CW_CH_LSB)
  - state encoding (IDLE, DATA, ARB)
- One sub-module: rr_arbiter (NUM_CH). Combinational one-hot winner from a request vector and pointer, plus a winner index output.

Test Plan (NUM_CH=4, BURST_MAX=4, DATA_IN_READY=1 unless stated):
1. Assert then release SYSTEM_RESET_N with no requests -> all outputs 0, CH_READY_OUT=4'b0000, TX_DATA_TO_SEND stays 0.
2. ch2 sends a 3-word packet -> output sequence:
   - 0xE000_0200_0000_0000 (ctrl)
   - 3 data words, in order, with TX_CTRL_OUT=0
   - 0x9000_0000_0000_0000 (idle+EOP)
   - then valid=0
3. ch0 sends a 6-word packet -> output sequence:
   - 0xE000_0000_0000_0000
   - 4 data words
   - 0xC000_0000_0000_0000 (burst, no SOP/EOP)
   - 2 data words
   - 0x9000_0000_0000_0000
4. All 4 channels present a 1-word packet simultaneously -> grants in order 0,1,2,3:
   - intermediate ctrl words 0xF000_0100…, 0xF000_0200…, 0xF000_0300… (all low-order bits 0)
   - final 0x9000_0000_0000_0000
5. DATA_IN_READY low for 3 cycles mid-burst -> TX_DATA_OUT stable, CH_READY_OUT=0, the downstream word count equals the source word count with no duplicates.
6. Async reset asserted mid-burst on ch3 -> outputs clear immediately. After release, a pending ch0 request wins first with ctrl word 0xE000_0000_0000_0000.

Source files
------------

// File: rtl/interlaken_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : interlaken_tx_pkg
//  Description : Shared definitions for the Interlaken TX burst scheduler:
//                control-word field positions, scheduler state encoding and
//                a helper that assembles a burst/idle control word.
//  Revision    : 1.0  initial release
// ============================================================================
package interlaken_tx_pkg;

    // Control-word bit positions
    localparam int CW_CTRL    = 63;  // always 1 in a control word
    localparam int CW_BURST   = 62;  // 1 = burst, 0 = idle
    localparam int CW_SOP     = 61;  // next burst starts a packet
    localparam int CW_EOP     = 60;  // previous burst ended a packet
    localparam int CW_CH_LSB  = 40;  // channel field [47:40]
    localparam int CW_CH_W    = 8;

    localparam int DATA_W     = 64;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ARB  = 2'd2
    } sched_state_t;

    // Assemble a control word; every bit outside the defined fields is zero.
    function automatic logic [DATA_W-1:0] make_ctrl_word(
        input logic                is_burst,
        input logic                sop,
        input logic                eop,
        input logic [CW_CH_W-1:0]  ch
    );
        logic [DATA_W-1:0] w;
        w                        = '0;
        w[CW_CTRL]               = 1'b1;
        w[CW_BURST]              = is_burst;
        w[CW_SOP]                = sop;
        w[CW_EOP]                = eop;
        w[CW_CH_LSB +: CW_CH_W]  = ch;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Searches the request
//                vector starting one position after the pointer (wrapping)
//                and returns the first requester as one-hot and as an index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_onehot,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // Priority search from pointer+1 around the ring; lowest distance wins.
    always_comb begin : p_search
        int w_pos;
        w_pos   = 0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_pos = (int'(i_ptr) + k) % NUM_CH;
            if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_pos[IDX_W-1:0];
            end
        end
    end

    // Expand the winning index into a one-hot grant vector.
    always_comb begin
        o_onehot = '0;
        if (w_found) begin
            o_onehot[w_idx] = 1'b1;
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_found;

endmodule
`default_nettype wire

// File: rtl/tx_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tx_burst_scheduler
//  Description : Multiplexes NUM_CH frame sources onto one 64-bit TX path.
//                Round-robin grants, packets cut into bursts of at most
//                BURST_MAX words, a burst/idle control word ahead of every
//                burst and after the last one. One registered output stage
//                with valid/ready toward the transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_burst_scheduler
    import interlaken_tx_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int BURST_MAX = 8
) (
    input  logic                 USER_CLK,
    input  logic                 SYSTEM_RESET_N,
    input  logic                 ENABLE,
    input  logic [NUM_CH*64-1:0] CH_DATA_IN,
    input  logic [NUM_CH-1:0]    CH_VALID_IN,
    input  logic [NUM_CH-1:0]    CH_LAST_IN,
    output logic [NUM_CH-1:0]    CH_READY_OUT,
    output logic [63:0]          TX_DATA_OUT,
    output logic                 TX_CTRL_OUT,
    output logic                 TX_DATA_TO_SEND,
    input  logic                 DATA_IN_READY,
    output logic [3:0]           CUR_CH_OUT
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Registered state and outputs
    sched_state_t       r_state;
    logic [63:0]        r_tx_data;
    logic               r_tx_ctrl;
    logic               r_tx_valid;
    logic [CH_W-1:0]    r_grant;
    logic [CH_W-1:0]    r_rr_ptr;
    logic [7:0]         r_burst_cnt;
    logic [NUM_CH-1:0]  r_sop_pending;
    logic               r_eop_flag;

    // Combinational helpers
    logic [63:0]        w_ch_data [NUM_CH];
    logic               w_load_en;
    logic [NUM_CH-1:0]  w_win_onehot;
    logic [CH_W-1:0]    w_win_idx;
    logic               w_any_req;
    logic               w_req_go;
    logic               w_win_sop;
    logic               w_grant_valid;
    logic               w_grant_last;
    logic [7:0]         w_cnt_next;
    logic               w_burst_full;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
            assign w_ch_data[g] = CH_DATA_IN[64*g +: 64];
        end
    endgenerate

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_rr_arbiter (
        .i_req    (CH_VALID_IN),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_any    (w_any_req)
    );

    // The output register may take a new word when empty or being drained.
    assign w_load_en     = !r_tx_valid || DATA_IN_READY;
    assign w_req_go      = ENABLE && w_any_req;
    assign w_win_sop     = |(r_sop_pending & w_win_onehot);
    assign w_grant_valid = CH_VALID_IN[r_grant];
    assign w_grant_last  = CH_LAST_IN[r_grant];
    assign w_cnt_next    = r_burst_cnt + 8'd1;
    assign w_burst_full  = (w_cnt_next == 8'(BURST_MAX));

    // Only the granted channel is pulled, and only when the output can load.
    always_comb begin
        CH_READY_OUT = '0;
        if (r_state == ST_DATA) begin
            CH_READY_OUT[r_grant] = w_load_en;
        end
    end

    // Scheduler FSM together with the output register it drives.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            r_state       <= ST_IDLE;
            r_tx_data     <= '0;
            r_tx_ctrl     <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_grant       <= '0;
            r_rr_ptr      <= CH_W'(NUM_CH - 1);
            r_burst_cnt   <= '0;
            r_sop_pending <= '1;
            r_eop_flag    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load_en) begin
                        if (w_req_go) begin
                            r_tx_data   <= make_ctrl_word(1'b1, w_win_sop, 1'b0, 8'(w_win_idx));
                            r_tx_ctrl   <= 1'b1;
                            r_tx_valid  <= 1'b1;
                            r_grant     <= w_win_idx;
                            r_rr_ptr    <= w_win_idx;
                            r_burst_cnt <= '0;
                            r_state     <= ST_DATA;
                        end else begin
                            r_tx_valid  <= 1'b0;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_load_en) begin
                        if (w_grant_valid) begin
                            r_tx_data              <= w_ch_data[r_grant];
                            r_tx_ctrl              <= 1'b0;
                            r_tx_valid             <= 1'b1;
                            r_burst_cnt            <= w_cnt_next;
                            // A packet boundary re-arms SOP; a split leaves it clear.
                            r_sop_pending[r_grant] <= w_grant_last;
                            if (w_grant_last) begin
                                r_eop_flag <= 1'b1;
                                r_state    <= ST_ARB;
                            end else if (w_burst_full) begin
                                r_eop_flag <= 1'b0;
                                r_state    <= ST_ARB;
                            end
                        end else begin
                            // Granted source stalled: emit a bubble, keep the grant.
                            r_tx_valid <= 1'b0;
                        end
                    end
                end

                ST_ARB: begin
                    if (w_load_en) begin
                        r_tx_ctrl  <= 1'b1;
                        r_tx_valid <= 1'b1;
                        if (w_req_go) begin
                            r_tx_data   <= make_ctrl_word(1'b1, w_win_sop, r_eop_flag, 8'(w_win_idx));
                            r_grant     <= w_win_idx;
                            r_rr_ptr    <= w_win_idx;
                            r_burst_cnt <= '0;
                            r_state     <= ST_DATA;
                        end else begin
                            r_tx_data   <= make_ctrl_word(1'b0, 1'b0, r_eop_flag, 8'd0);
                            r_state     <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX_DATA_OUT     = r_tx_data;
    assign TX_CTRL_OUT     = r_tx_ctrl;
    assign TX_DATA_TO_SEND = r_tx_valid;
    assign CUR_CH_OUT      = 4'(r_grant);

endmodule
`default_nettype wire

// File: tb/tb_tx_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_burst_scheduler
//  Description : Self-checking bench for tx_burst_scheduler (4 channels,
//                bursts of 4). Directed scenarios plus a randomized run
//                whose output stream is parsed against per-channel packets.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tx_burst_scheduler;

    localparam int NUM_CH    = 4;
    localparam int BURST_MAX = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic [NUM_CH*64-1:0] ch_data;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH-1:0]    ch_last;
    logic [NUM_CH-1:0]    ch_ready;
    logic [63:0]          tx_data;
    logic                 tx_ctrl;
    logic                 tx_valid;
    logic                 dready;
    logic [3:0]           cur_ch;

    int checks = 0;
    int errors = 0;

    logic [64:0]       src_q  [NUM_CH][$];  // {last, data} still to offer
    logic [64:0]       ref_ch [NUM_CH][$];  // {last, data} expected downstream
    logic [64:0]       out_q  [$];          // {ctrl, data} accepted downstream
    logic [64:0]       exp_q  [$];
    logic [NUM_CH-1:0] gate = '0;

    always #5 clk = ~clk;

    tx_burst_scheduler #(
        .NUM_CH    (NUM_CH),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .USER_CLK        (clk),
        .SYSTEM_RESET_N  (rst_n),
        .ENABLE          (enable),
        .CH_DATA_IN      (ch_data),
        .CH_VALID_IN     (ch_valid),
        .CH_LAST_IN      (ch_last),
        .CH_READY_OUT    (ch_ready),
        .TX_DATA_OUT     (tx_data),
        .TX_CTRL_OUT     (tx_ctrl),
        .TX_DATA_TO_SEND (tx_valid),
        .DATA_IN_READY   (dready),
        .CUR_CH_OUT      (cur_ch)
    );

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_sources();
        for (int c = 0; c < NUM_CH; c++) begin
            if (src_q[c].size() > 0) begin
                ch_valid[c]         = ~gate[c];
                ch_last[c]          = src_q[c][0][64];
                ch_data[c*64 +: 64] = src_q[c][0][63:0];
            end else begin
                ch_valid[c]         = 1'b0;
                ch_last[c]          = 1'b0;
                ch_data[c*64 +: 64] = '0;
            end
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance the sources.
    task automatic step();
        logic [NUM_CH-1:0] fire;
        @(negedge clk);
        fire = ch_valid & ch_ready;
        if (tx_valid && dready) out_q.push_back({tx_ctrl, tx_data});
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fire[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        end
        drive_sources();
    endtask

    task automatic push_packet(input int c, input int len);
        logic [64:0] w;
        for (int i = 0; i < len; i++) begin
            w = {(i == len - 1), $urandom(), $urandom()};
            src_q[c].push_back(w);
            ref_ch[c].push_back(w);
        end
    endtask

    task automatic expect_ctrl(input logic [63:0] cw);
        exp_q.push_back({1'b1, cw});
    endtask

    task automatic expect_data(input int c, input int n);
        logic [64:0] w;
        for (int i = 0; i < n; i++) begin
            w = ref_ch[c].pop_front();
            exp_q.push_back({1'b0, w[63:0]});
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        gate  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            src_q[c].delete();
            ref_ch[c].delete();
        end
        drive_sources();
        repeat (2) step();
        rst_n = 1'b1;
        out_q.delete();
    endtask

    // Run until the expected number of words is seen (bounded), then compare.
    task automatic run_and_compare(input string name, input int budget);
        int          n;
        int          cyc;
        logic [64:0] obs;
        n   = exp_q.size();
        cyc = 0;
        while (out_q.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        repeat (6) step();
        check({name, "_count"}, 65'(out_q.size()), 65'(n));
        for (int i = 0; i < n; i++) begin
            obs = (i < out_q.size()) ? out_q[i] : '0;
            check($sformatf("%s_w%0d", name, i), obs, exp_q[i]);
        end
        check({name, "_quiet"}, 65'(tx_valid), 65'(0));
        out_q.delete();
        exp_q.delete();
    endtask

    // Walk the random-run output stream and re-derive it from packet rules.
    task automatic parse_random();
        logic [64:0] w;
        logic [64:0] e;
        int          cur;
        int          blen;
        bit          in_burst;
        bit          ended_last;
        bit          pkt_open [NUM_CH];
        cur = 0; blen = 0; in_burst = 0; ended_last = 0;
        for (int c = 0; c < NUM_CH; c++) pkt_open[c] = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            w = out_q[i];
            if (w[64]) begin
                if (in_burst) begin
                    check("rnd_burst_len", 65'(ended_last || blen == BURST_MAX), 65'(1));
                    check("rnd_eop", 65'(w[60]), 65'(ended_last));
                end else begin
                    check("rnd_eop_after_idle", 65'(w[60]), 65'(0));
                end
                check("rnd_cw_fmt", 65'({w[63], w[63:0] & 64'h0FFF_00FF_FFFF_FFFF}), {1'b1, 64'h0});
                if (w[62]) begin
                    cur = int'(w[47:40]);
                    check("rnd_ch_range", 65'(cur < NUM_CH), 65'(1));
                    if (cur < NUM_CH) check("rnd_sop", 65'(w[61]), 65'(!pkt_open[cur]));
                    in_burst = 1; blen = 0; ended_last = 0;
                end else begin
                    check("rnd_idle_fields", 65'({w[61], w[47:40]}), 65'(0));
                    in_burst = 0;
                end
            end else begin
                check("rnd_data_in_burst", 65'(in_burst && !ended_last), 65'(1));
                if (in_burst && cur < NUM_CH) begin
                    e = (ref_ch[cur].size() > 0) ? ref_ch[cur].pop_front() : '1;
                    check($sformatf("rnd_data_ch%0d", cur), {1'b0, w[63:0]}, {1'b0, e[63:0]});
                    blen++;
                    check("rnd_burst_max", 65'(blen <= BURST_MAX), 65'(1));
                    ended_last    = e[64];
                    pkt_open[cur] = !e[64];
                end
            end
        end
        check("rnd_final_idle", (out_q.size() > 0) ? out_q[out_q.size()-1] : '0,
              {1'b1, 64'h9000_0000_0000_0000});
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("rnd_drained_ch%0d", c), 65'(ref_ch[c].size()), 65'(0));
        end
    endtask

    initial begin
        int pend;
        int cyc;
        logic [63:0] held;

        rst_n    = 1'b0;
        enable   = 1'b1;
        dready   = 1'b1;
        ch_valid = '0;
        ch_last  = '0;
        ch_data  = '0;
        drive_sources();
        repeat (3) step();

        // 1: reset state, no requests
        check("rst_valid", 65'(tx_valid), 65'(0));
        check("rst_data",  {tx_ctrl, tx_data}, 65'(0));
        check("rst_cur",   65'(cur_ch), 65'(0));
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("idle_valid%0d", k), 65'(tx_valid), 65'(0));
            check($sformatf("idle_ready%0d", k), 65'(ch_ready), 65'(0));
        end
        check("idle_data", {tx_ctrl, tx_data}, 65'(0));
        out_q.delete();

        // 2: ch2, 3-word packet
        push_packet(2, 3);
        drive_sources();
        expect_ctrl(64'hE000_0200_0000_0000);
        expect_data(2, 3);
        expect_ctrl(64'h9000_0000_0000_0000);
        run_and_compare("t2", 40);

        // 3: ch0, 6-word packet split 4 + 2
        push_packet(0, 6);
        drive_sources();
        expect_ctrl(64'hE000_0000_0000_0000);
        expect_data(0, 4);
        expect_ctrl(64'hC000_0000_0000_0000);
        expect_data(0, 2);
        expect_ctrl(64'h9000_0000_0000_0000);
        run_and_compare("t3", 60);

        // 4: all channels one word at once, fresh pointer
        apply_reset();
        for (int c = 0; c < NUM_CH; c++) push_packet(c, 1);
        drive_sources();
        expect_ctrl(64'hE000_0000_0000_0000);
        expect_data(0, 1);
        expect_ctrl(64'hF000_0100_0000_0000);
        expect_data(1, 1);
        expect_ctrl(64'hF000_0200_0000_0000);
        expect_data(2, 1);
        expect_ctrl(64'hF000_0300_0000_0000);
        expect_data(3, 1);
        expect_ctrl(64'h9000_0000_0000_0000);
        run_and_compare("t4", 60);

        // 5: downstream stall mid-burst on ch1
        push_packet(1, 4);
        drive_sources();
        cyc = 0;
        while (out_q.size() < 2 && cyc < 20) begin
            step();
            cyc++;
        end
        dready = 1'b0;
        held   = tx_data;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t5_hold%0d", k),  {1'b0, tx_data}, {1'b0, held});
            check($sformatf("t5_ready%0d", k), 65'(ch_ready), 65'(0));
            check($sformatf("t5_valid%0d", k), 65'(tx_valid), 65'(1));
        end
        dready = 1'b1;
        expect_ctrl(64'hE000_0100_0000_0000);
        expect_data(1, 4);
        expect_ctrl(64'h9000_0000_0000_0000);
        run_and_compare("t5", 40);

        // 6: async reset in the middle of a ch3 burst
        push_packet(3, 4);
        drive_sources();
        cyc = 0;
        while (out_q.size() < 2 && cyc < 20) begin
            step();
            cyc++;
        end
        check("t6_cur_before", 65'(cur_ch), 65'(3));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 65'(tx_valid), 65'(0));
        check("t6_rst_data",  {tx_ctrl, tx_data}, 65'(0));
        check("t6_rst_cur",   65'(cur_ch), 65'(0));
        check("t6_rst_ready", 65'(ch_ready), 65'(0));
        src_q[3].delete();
        ref_ch[3].delete();
        push_packet(0, 1);
        drive_sources();
        repeat (2) step();
        out_q.delete();
        rst_n = 1'b1;
        expect_ctrl(64'hE000_0000_0000_0000);
        expect_data(0, 1);
        expect_ctrl(64'h9000_0000_0000_0000);
        run_and_compare("t6", 30);

        // Randomized traffic with source gaps and downstream back-pressure
        apply_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            int npk;
            npk = 1 + int'($urandom_range(2));
            for (int p = 0; p < npk; p++) push_packet(c, 1 + int'($urandom_range(8)));
        end
        pend = 1;
        cyc  = 0;
        while (pend != 0 && cyc < 3000) begin
            gate   = NUM_CH'($urandom());
            dready = ($urandom_range(3) != 0);
            drive_sources();
            step();
            cyc++;
            pend = 0;
            for (int c = 0; c < NUM_CH; c++) pend += src_q[c].size();
        end
        gate   = '0;
        dready = 1'b1;
        drive_sources();
        repeat (12) step();
        check("rnd_sources_empty", 65'(pend), 65'(0));
        parse_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
